// File: rtl/ut_ctrl_sequencer.sv
// ut_ctrl_sequencer: UT core control FSM, PC and memory address mux; define UT_SEQ_HALT_EN to enable HLT.
module ut_ctrl_sequencer #(
    parameter logic [5:0] PC_RESET = 6'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic [2:0] code_op,
    input  logic [5:0] ADR_RI,
    input  logic       carry,
    output logic       load_RI,
    output logic       load_ACC,
    output logic       load_carry,
    output logic       clr_carry,
    output logic [1:0] alu_sel,
    output logic       mem_en,
    output logic       mem_we,
    output logic [5:0] mem_addr,
    output logic [5:0] pc,
    output logic       halt
);
    typedef enum logic [2:0] {FETCH, LOAD_I, DECODE, OP_RD, EXEC, STORE, HALTED} state_t;
    localparam logic [2:0] OP_NOR = 3'b000, OP_ADD = 3'b001, OP_STA = 3'b010, OP_JCC = 3'b011,
                           OP_LDA = 3'b100, OP_JMP = 3'b101, OP_HLT = 3'b111;
    state_t state, state_nx;
    logic [5:0] pc_nx;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
            pc    <= PC_RESET;
        end else if (ce) begin
            state <= state_nx;
            pc    <= pc_nx;
        end
    end
    always_comb begin
        state_nx   = state;
        pc_nx      = pc;
        load_RI    = 1'b0;
        load_ACC   = 1'b0;
        load_carry = 1'b0;
        clr_carry  = 1'b0;
        alu_sel    = 2'b00;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        halt       = 1'b0;
        mem_addr   = (state == FETCH || state == LOAD_I || state == DECODE || state == HALTED) ? pc : ADR_RI;
        case (state)
            FETCH: begin
                mem_en   = ce;
                state_nx = LOAD_I;
            end
            LOAD_I: begin
                load_RI  = ce;
                pc_nx    = pc + 6'd1;
                state_nx = DECODE;
            end
            DECODE: begin
                state_nx = FETCH;
                case (code_op)
                    OP_NOR, OP_ADD, OP_LDA: state_nx = OP_RD;
                    OP_STA: state_nx = STORE;
                    OP_JCC: begin
                        clr_carry = ce;
                        pc_nx     = carry ? pc : ADR_RI;
                    end
                    OP_JMP: pc_nx = ADR_RI;
`ifdef UT_SEQ_HALT_EN
                    OP_HLT: state_nx = HALTED;
`endif
                    default: state_nx = FETCH;
                endcase
            end
            OP_RD: begin
                mem_en   = ce;
                state_nx = EXEC;
            end
            EXEC: begin
                load_ACC   = ce;
                load_carry = ce && code_op == OP_ADD;
                alu_sel    = code_op == OP_ADD ? 2'b01 : code_op == OP_LDA ? 2'b10 : 2'b00;
                state_nx   = FETCH;
            end
            STORE: begin
                mem_en   = ce;
                mem_we   = ce;
                state_nx = FETCH;
            end
            HALTED: begin
`ifdef UT_SEQ_HALT_EN
                halt = 1'b1;
`endif
                state_nx = HALTED;
            end
            default: state_nx = FETCH;
        endcase
    end
endmodule

// File: tb/tb_ut_ctrl_sequencer.sv
// tb_ut_ctrl_sequencer: directed bench for ut_ctrl_sequencer with hand-computed expectations.
module tb_ut_ctrl_sequencer;
    logic       clk = 1'b0, rst, ce, carry;
    logic [2:0] code_op;
    logic [5:0] ADR_RI, mem_addr, pc, exp_pc;
    logic       load_RI, load_ACC, load_carry, clr_carry, mem_en, mem_we, halt;
    logic [1:0] alu_sel;
    int         checks = 0, errors = 0, cnt;

    ut_ctrl_sequencer dut (
        .clk(clk), .rst(rst), .ce(ce), .code_op(code_op), .ADR_RI(ADR_RI), .carry(carry),
        .load_RI(load_RI), .load_ACC(load_ACC), .load_carry(load_carry), .clr_carry(clr_carry),
        .alu_sel(alu_sel), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .pc(pc), .halt(halt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Runs FETCH, LOAD_I and leaves the bench sampling in DECODE.
    task automatic fetch_decode(input logic [2:0] op, input logic [5:0] adr, input logic c);
        code_op = op;
        ADR_RI  = adr;
        carry   = c;
        check("fetch_addr", mem_addr, exp_pc);
        check("fetch_en", mem_en, 1);
        check("fetch_ri", load_RI, 0);
        tick();
        check("loadi_ri", load_RI, 1);
        check("loadi_en", mem_en, 0);
        tick();
        exp_pc = exp_pc + 6'd1;
        check("decode_pc", pc, exp_pc);
        check("decode_ri", load_RI, 0);
    endtask

    initial begin
        rst = 1'b1; ce = 1'b1; carry = 1'b0; code_op = 3'b110; ADR_RI = 6'd0; exp_pc = 6'd0;
        tick();
        check("rst_pc", pc, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_en", mem_en, 1);
        check("rst_strobes", {load_RI, load_ACC, load_carry, clr_carry, mem_we, halt}, 0);
        check("rst_alu", alu_sel, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 64; i++) begin
            fetch_decode(3'b110, 6'd0, 1'b0);
            tick();
        end
        check("nop_wrap_pc", pc, 0);

        fetch_decode(3'b001, 6'h2A, 1'b0);
        tick();
        check("add_rd_addr", mem_addr, 6'h2A);
        check("add_rd_en", mem_en, 1);
        check("add_rd_acc", load_ACC, 0);
        tick();
        check("add_ex_acc", load_ACC, 1);
        check("add_ex_carry", load_carry, 1);
        check("add_ex_alu", alu_sel, 2'b01);
        check("add_ex_pc", pc, 1);
        tick();

        fetch_decode(3'b010, 6'h3F, 1'b0);
        cnt = int'(mem_we);
        tick();
        check("sta_we", mem_we, 1);
        check("sta_addr", mem_addr, 6'h3F);
        check("sta_en", mem_en, 1);
        cnt += int'(mem_we);
        tick();
        cnt += int'(mem_we);
        check("sta_we_count", cnt, 1);
        check("sta_next_addr", mem_addr, 2);

        fetch_decode(3'b011, 6'h10, 1'b0);
        check("jcc0_clr", clr_carry, 1);
        tick();
        exp_pc = 6'h10;
        check("jcc0_clr_once", clr_carry, 0);
        check("jcc0_addr", mem_addr, 6'h10);

        fetch_decode(3'b011, 6'h20, 1'b1);
        check("jcc1_clr", clr_carry, 1);
        tick();
        check("jcc1_addr", mem_addr, 6'h11);

        fetch_decode(3'b101, 6'h05, 1'b0);
        tick();
        exp_pc = 6'h05;
        check("jmp_addr", mem_addr, 6'h05);

        fetch_decode(3'b100, 6'h22, 1'b0);
        tick();
        check("lda_rd_en", mem_en, 1);
        ce = 1'b0;
        #1;
        check("lda_ce0_en", mem_en, 0);
        cnt = 0;
        repeat (4) begin
            tick();
            check("lda_stall_strobes", {load_RI, load_ACC, load_carry, clr_carry, mem_en, mem_we}, 0);
            check("lda_stall_addr", mem_addr, 6'h22);
            cnt += int'(load_ACC);
        end
        ce = 1'b1;
        #1;
        check("lda_resume_en", mem_en, 1);
        tick();
        check("lda_ex_acc", load_ACC, 1);
        check("lda_ex_alu", alu_sel, 2'b10);
        check("lda_ex_carry", load_carry, 0);
        cnt += int'(load_ACC);
        tick();
        cnt += int'(load_ACC);
        check("lda_acc_count", cnt, 1);

        fetch_decode(3'b111, 6'h00, 1'b0);
        tick();
`ifdef UT_SEQ_HALT_EN
        check("hlt_halt", halt, 1);
        check("hlt_en", mem_en, 0);
        repeat (3) begin
            tick();
            check("hlt_pc", pc, exp_pc);
            check("hlt_stay", halt, 1);
        end
        rst = 1'b1;
        #1;
        check("hlt_rst", halt, 0);
        tick();
        rst = 1'b0;
        exp_pc = 6'd0;
`else
        check("hlt_nop_halt", halt, 0);
        check("hlt_nop_addr", mem_addr, exp_pc);
        check("hlt_nop_en", mem_en, 1);
`endif

        fetch_decode(3'b001, 6'h15, 1'b0);
        tick();
        tick();
        check("rst_ex_acc", load_ACC, 1);
        rst = 1'b1;
        #1;
        check("rst_ex_strobes", {load_RI, load_ACC, load_carry, clr_carry, mem_we, halt}, 0);
        check("rst_ex_alu", alu_sel, 0);
        check("rst_ex_pc", pc, 0);
        check("rst_ex_addr", mem_addr, 0);
        check("rst_ex_en", mem_en, 1);
        tick();
        rst = 1'b0;
        exp_pc = 6'd0;
        fetch_decode(3'b110, 6'h00, 1'b0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
